// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t          : receiver FSM state encoding
//   DEFAULT_CLK_PER_BIT : default clk cycles per bit period
//   DEFAULT_N_DATA      : default data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 104;
  localparam int DEFAULT_N_DATA      = 8;

endpackage

// File: rtl/uart_rx_sequencer_bit_timer.sv
// bit_timer
// Down-counting bit-period timer with a one-cycle tick at terminal count.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   load load_value this cycle (takes priority over counting)
//   load_value in   value loaded; tick fires load_value+1 cycles after load
//   tick       out  one-cycle pulse when the armed count reaches zero
module bit_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;
  logic             r_armed;

  // r_armed turns the zero state into a single pulse; reloading on the
  // tick cycle keeps the period exactly load_value+1 with no gap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (load) begin
      r_count <= load_value;
      r_armed <= 1'b1;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_armed <= 1'b0;
    end
  end

  assign tick = r_armed && (r_count == '0);

endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer
// UART receiver: synchronizes rx, detects the start edge, samples each bit
// at mid-period and hands completed frames to a valid/ready consumer.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rx          in   asynchronous serial line, idle high
//   data        out  last delivered frame, LSB received first
//   data_valid  out  data holds an unconsumed frame
//   data_ready  in   consumer accepts data while data_valid is high
//   framing_err out  one-cycle pulse after a low stop bit
//   overrun     out  one-cycle pulse when a good frame is dropped
//   busy        out  high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, watching for a 1->0 edge on rxs
// START     | waiting for mid start bit; a high sample here is a glitch
// DATA      | sampling N_DATA data bits at mid-bit, LSB first
// STOP      | waiting for mid stop bit; deliver on high, error on low
// WAIT_IDLE | after a framing error, hold until the line returns high
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int N_DATA      = DEFAULT_N_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [N_DATA-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              framing_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TW = $clog2(CLK_PER_BIT) + 1;
  localparam int CW = $clog2(N_DATA);
  // Loaded on the start-detect cycle: tick lands floor(CLK_PER_BIT/2) later.
  localparam logic [TW-1:0] LD_HALF = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LD_FULL = TW'(CLK_PER_BIT - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_rxs_d;
  rx_state_t         r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic [N_DATA-1:0] r_shift;
  logic [N_DATA-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_ovr;

  logic              w_rxs;
  logic              w_tick;
  rx_state_t         w_next_state;
  logic              w_load;
  logic [TW-1:0]     w_load_value;
  logic              w_shift;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_deliver;
  logic              w_ferr_set;

  assign w_rxs = r_sync2;

  bit_timer #(.WIDTH(TW)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_value (w_load_value),
    .tick       (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_value = LD_FULL;
    w_shift      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_deliver    = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs && r_rxs_d) begin
          w_next_state = START;
          w_load       = 1'b1;
          w_load_value = LD_HALF;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_next_state = IDLE;
          end else begin
            w_next_state = DATA;
            w_load       = 1'b1;
            w_cnt_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          w_load  = 1'b1;
          if (r_bit_cnt == CW'(N_DATA - 1)) begin
            w_next_state = STOP;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_deliver    = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_next_state = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rxs) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxs_d   <= 1'b1;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rxs_d <= w_rxs;

      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end

      if (w_shift) begin
        r_shift <= {w_rxs, r_shift[N_DATA-1:1]};
      end

      r_ferr <= w_ferr_set;
      r_ovr  <= 1'b0;

      // A handshake in the same cycle as a delivery frees the holding
      // register, so the new frame replaces the old one without overrun.
      if (w_deliver) begin
        if (!r_valid || data_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = (r_state != IDLE);

endmodule
